// File: rtl/spi_cmd_pkg.sv
// Shared definitions for the SPI command sequencer: command codes, FSM
// state encoding and STATUS reply flag layout.
// Optional feature macro: SPI_CMD_CKSUM_EN (enables command CMD_CKSUM).
package spi_cmd_pkg;

  // Command byte values (first byte after chip select falls)
  localparam logic [7:0] CMD_WRITE  = 8'h01;
  localparam logic [7:0] CMD_READ   = 8'h02;
  localparam logic [7:0] CMD_STATUS = 8'h03;
  localparam logic [7:0] CMD_CKSUM  = 8'h04;

  // Bit positions inside the second STATUS reply byte
  localparam int STAT_ILLEGAL_BIT = 0;
  localparam int STAT_OVERRUN_BIT = 1;

  // Sequencer states
  typedef enum logic [3:0] {
    ST_IDLE     = 4'd0,
    ST_CMD      = 4'd1,
    ST_ADDR_HI  = 4'd2,
    ST_ADDR_LO  = 4'd3,
    ST_WR_DATA  = 4'd4,
    ST_WR_WAIT  = 4'd5,
    ST_RD_FETCH = 4'd6,
    ST_RD_DATA  = 4'd7,
    ST_HOLD     = 4'd8,
    ST_ERR      = 4'd9,
    ST_DRAIN    = 4'd10
  } state_t;

  // Packs the sticky error flags into the STATUS flag reply byte
  function automatic logic [7:0] status_byte(input logic overrun, input logic illegal);
    logic [7:0] b;
    b                   = 8'h00;
    b[STAT_OVERRUN_BIT] = overrun;
    b[STAT_ILLEGAL_BIT] = illegal;
    return b;
  endfunction

endpackage

// File: rtl/cdc_sync2.sv
// Generic two-flop synchronizer for a single asynchronous level.
// Reset value is configurable; chip select uses 1 so it reads as idle.
module cdc_sync2 #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  // Two-stage resynchronization of the asynchronous input
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/spi_cmd_ctrl.sv
// SPI command sequencer (FPGA-clock side of the SPI slave byte interface).
// Decodes a 3-byte header (command, addr hi, addr lo) and runs byte-wide
// write/read bursts on a req/ack memory port, returning reply bytes through
// the slave TX load pulse. STATUS returns an ID byte then the error flags.
// Optional feature macro: SPI_CMD_CKSUM_EN adds command 0x04, which returns
// an 8-bit wrapping sum of all bytes written since reset or last readout.
//
// Memory handshake: o_Mem_Req rises together with valid o_Mem_We,
// o_Mem_Addr and o_Mem_Wdata and stays high, with those fields stable,
// until the cycle i_Mem_Ack is high; i_Mem_Rdata is sampled in that same
// cycle and req drops on the following edge.
module spi_cmd_ctrl
  import spi_cmd_pkg::*;
#(
  parameter int         ADDR_W    = 16,
  parameter logic [7:0] STATUS_ID = 8'hA5
) (
  input  logic              i_Clk,
  input  logic              i_Rst_L,
  input  logic              i_RX_DV,
  input  logic [7:0]        i_RX_Byte,
  input  logic              i_SPI_CS_n,
  output logic              o_TX_DV,
  output logic [7:0]        o_TX_Byte,
  output logic              o_Mem_Req,
  output logic              o_Mem_We,
  output logic [ADDR_W-1:0] o_Mem_Addr,
  output logic [7:0]        o_Mem_Wdata,
  input  logic              i_Mem_Ack,
  input  logic [7:0]        i_Mem_Rdata,
  output logic              o_Busy,
  output logic              o_Err,
  output state_t            o_Dbg_State
);

  state_t            state_q, state_d;
  logic              cs_s, cs_q;
  logic              cs_rise, cs_fall;
  logic              req_q, req_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        wdata_q, wdata_d;
  logic              tx_dv_q, tx_dv_d;
  logic [7:0]        tx_byte_q, tx_byte_d;
  logic              ovr_q, ovr_d;
  logic              ill_q, ill_d;
  logic [7:0]        addr_hi_q, addr_hi_d;
  logic              is_wr_q, is_wr_d;
  logic              hold_stat_q, hold_stat_d;
`ifdef SPI_CMD_CKSUM_EN
  logic [7:0]        sum_q, sum_d;
`endif

  cdc_sync2 #(.RST_VAL(1'b1)) u_cs_sync (
    .clk   (i_Clk),
    .rst_n (i_Rst_L),
    .d     (i_SPI_CS_n),
    .q     (cs_s)
  );

  // Edge detection on the synchronized chip select
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) cs_q <= 1'b1;
    else          cs_q <= cs_s;
  end

  assign cs_rise = cs_s & ~cs_q;
  assign cs_fall = cs_q & ~cs_s;

  // State and datapath registers
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      state_q     <= ST_IDLE;
      req_q       <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= 8'h00;
      tx_dv_q     <= 1'b0;
      tx_byte_q   <= 8'h00;
      ovr_q       <= 1'b0;
      ill_q       <= 1'b0;
      addr_hi_q   <= 8'h00;
      is_wr_q     <= 1'b0;
      hold_stat_q <= 1'b0;
`ifdef SPI_CMD_CKSUM_EN
      sum_q       <= 8'h00;
`endif
    end else begin
      state_q     <= state_d;
      req_q       <= req_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      tx_dv_q     <= tx_dv_d;
      tx_byte_q   <= tx_byte_d;
      ovr_q       <= ovr_d;
      ill_q       <= ill_d;
      addr_hi_q   <= addr_hi_d;
      is_wr_q     <= is_wr_d;
      hold_stat_q <= hold_stat_d;
`ifdef SPI_CMD_CKSUM_EN
      sum_q       <= sum_d;
`endif
    end
  end

  // Next-state and next-datapath decode
  always_comb begin
    state_d     = state_q;
    req_d       = req_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    tx_dv_d     = 1'b0;
    tx_byte_d   = tx_byte_q;
    ovr_d       = ovr_q;
    ill_d       = ill_q;
    addr_hi_d   = addr_hi_q;
    is_wr_d     = is_wr_q;
    hold_stat_d = hold_stat_q;
`ifdef SPI_CMD_CKSUM_EN
    // Every completed memory write contributes to the running sum
    sum_d = sum_q;
    if (req_q && we_q && i_Mem_Ack) sum_d = sum_q + wdata_q;
`endif

    if (state_q == ST_DRAIN) begin
      // Transaction already ended; only finish the outstanding access
      if (i_RX_DV) ovr_d = 1'b1;
      if (i_Mem_Ack) begin
        req_d   = 1'b0;
        state_d = ST_IDLE;
      end
    end else if (cs_rise && (state_q != ST_IDLE)) begin
      // End of transaction wins over any byte arriving in the same cycle
      if (req_q && !i_Mem_Ack) begin
        state_d = ST_DRAIN;
      end else begin
        req_d   = 1'b0;
        state_d = ST_IDLE;
      end
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (cs_fall) state_d = ST_CMD;
        end

        ST_CMD: begin
          if (i_RX_DV) begin
            case (i_RX_Byte)
              CMD_WRITE: begin
                is_wr_d = 1'b1;
                state_d = ST_ADDR_HI;
              end
              CMD_READ: begin
                is_wr_d = 1'b0;
                state_d = ST_ADDR_HI;
              end
              CMD_STATUS: begin
                tx_dv_d     = 1'b1;
                tx_byte_d   = STATUS_ID;
                hold_stat_d = 1'b1;
                state_d     = ST_HOLD;
              end
`ifdef SPI_CMD_CKSUM_EN
              CMD_CKSUM: begin
                tx_dv_d     = 1'b1;
                tx_byte_d   = sum_q;
                sum_d       = 8'h00;
                hold_stat_d = 1'b0;
                state_d     = ST_HOLD;
              end
`endif
              default: begin
                ill_d   = 1'b1;
                state_d = ST_ERR;
              end
            endcase
          end
        end

        ST_ADDR_HI: begin
          if (i_RX_DV) begin
            addr_hi_d = i_RX_Byte;
            state_d   = ST_ADDR_LO;
          end
        end

        ST_ADDR_LO: begin
          if (i_RX_DV) begin
            // 16-bit header address, resized to the memory address width
            addr_d = ADDR_W'({addr_hi_q, i_RX_Byte});
            if (is_wr_q) begin
              state_d = ST_WR_DATA;
            end else begin
              req_d   = 1'b1;
              we_d    = 1'b0;
              state_d = ST_RD_FETCH;
            end
          end
        end

        ST_WR_DATA: begin
          if (i_RX_DV) begin
            req_d   = 1'b1;
            we_d    = 1'b1;
            wdata_d = i_RX_Byte;
            state_d = ST_WR_WAIT;
          end
        end

        ST_WR_WAIT: begin
          // A byte arriving before the write completes is dropped
          if (i_RX_DV) ovr_d = 1'b1;
          if (i_Mem_Ack) begin
            req_d   = 1'b0;
            addr_d  = addr_q + ADDR_W'(1);
            state_d = ST_WR_DATA;
          end
        end

        ST_RD_FETCH: begin
          if (i_Mem_Ack) begin
            req_d     = 1'b0;
            tx_dv_d   = 1'b1;
            tx_byte_d = i_Mem_Rdata;
            addr_d    = addr_q + ADDR_W'(1);
            state_d   = ST_RD_DATA;
          end
        end

        ST_RD_DATA: begin
          // The host's dummy byte triggers the prefetch of the next byte
          if (i_RX_DV) begin
            req_d   = 1'b1;
            we_d    = 1'b0;
            state_d = ST_RD_FETCH;
          end
        end

        ST_HOLD: begin
          if (i_RX_DV) begin
            tx_dv_d = 1'b1;
            if (hold_stat_q) begin
              tx_byte_d   = status_byte(ovr_q, ill_q);
              ovr_d       = 1'b0;
              ill_d       = 1'b0;
              hold_stat_d = 1'b0;
            end else begin
              tx_byte_d = 8'h00;
            end
          end
        end

        ST_ERR: begin
          // Bytes are ignored until chip select rises
        end

        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  assign o_TX_DV     = tx_dv_q;
  assign o_TX_Byte   = tx_byte_q;
  assign o_Mem_Req   = req_q;
  assign o_Mem_We    = we_q;
  assign o_Mem_Addr  = addr_q;
  assign o_Mem_Wdata = wdata_q;
  assign o_Busy      = (state_q != ST_IDLE);
  assign o_Err       = ovr_q | ill_q;
  assign o_Dbg_State = state_q;

endmodule

// File: tb/tb_spi_cmd_ctrl.sv
// Testbench for spi_cmd_ctrl: directed SPI byte sequences, a behavioural
// memory with programmable ack latency, and queue-based scoreboards for
// memory accesses and TX reply bytes.
module tb_spi_cmd_ctrl;
  import spi_cmd_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        rx_dv;
  logic [7:0]  rx_byte;
  logic        cs_n;
  logic        tx_dv;
  logic [7:0]  tx_byte;
  logic        mem_req;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        mem_ack;
  logic [7:0]  mem_rdata;
  logic        busy;
  logic        err;
  state_t      dbg_state;

  logic [7:0]  mem [0:65535];
  logic [24:0] exp_req_q[$];
  logic [7:0]  exp_tx_q[$];
  int          n_tests = 0;
  int          n_fail  = 0;
  int          mem_lat = 0;
  int          lat_cnt = 0;

  spi_cmd_ctrl #(.ADDR_W(16), .STATUS_ID(8'hA5)) dut (
    .i_Clk       (clk),
    .i_Rst_L     (rst_n),
    .i_RX_DV     (rx_dv),
    .i_RX_Byte   (rx_byte),
    .i_SPI_CS_n  (cs_n),
    .o_TX_DV     (tx_dv),
    .o_TX_Byte   (tx_byte),
    .o_Mem_Req   (mem_req),
    .o_Mem_We    (mem_we),
    .o_Mem_Addr  (mem_addr),
    .o_Mem_Wdata (mem_wdata),
    .i_Mem_Ack   (mem_ack),
    .i_Mem_Rdata (mem_rdata),
    .o_Busy      (busy),
    .o_Err       (err),
    .o_Dbg_State (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- check helper ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- memory model + request monitor ----------------
  initial begin : mem_model
    logic [24:0] act;
    mem_ack   = 1'b0;
    mem_rdata = 8'h00;
    forever begin
      @(negedge clk);
      mem_ack = 1'b0;
      if (mem_req && rst_n) begin
        if (lat_cnt >= mem_lat) begin
          act = {mem_we, mem_addr, (mem_we ? mem_wdata : 8'h00)};
          if (exp_req_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL mem_req: unexpected access %0h", act);
          end else begin
            check("mem_req", {7'd0, act}, {7'd0, exp_req_q.pop_front()});
          end
          mem_ack = 1'b1;
          if (mem_we) mem[mem_addr] = mem_wdata;
          else        mem_rdata = mem[mem_addr];
          lat_cnt = 0;
        end else begin
          lat_cnt++;
        end
      end else begin
        lat_cnt = 0;
      end
    end
  end

  // ---------------- TX monitor ----------------
  initial begin : tx_monitor
    forever begin
      @(negedge clk);
      if (tx_dv) begin
        if (exp_tx_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL tx_byte: unexpected reply %0h", tx_byte);
        end else begin
          check("tx_byte", {24'd0, tx_byte}, {24'd0, exp_tx_q.pop_front()});
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic cs_low();
    @(negedge clk);
    cs_n = 1'b0;
    wait_cycles(5);
  endtask

  task automatic cs_high();
    @(negedge clk);
    cs_n = 1'b1;
    wait_cycles(6);
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    @(negedge clk);
    rx_dv   = 1'b1;
    rx_byte = b;
    @(negedge clk);
    rx_dv   = 1'b0;
    wait_cycles(gap);
  endtask

  task automatic exp_wr(input logic [15:0] a, input logic [7:0] d);
    exp_req_q.push_back({1'b1, a, d});
  endtask

  task automatic exp_rd(input logic [15:0] a);
    exp_req_q.push_back({1'b0, a, 8'h00});
  endtask

  // ---------------- stimulus ----------------
  initial begin : stimulus
    int cnt;
    rst_n   = 1'b0;
    cs_n    = 1'b1;
    rx_dv   = 1'b0;
    rx_byte = 8'h00;
    mem[16'h0010] = 8'h5C;
    mem[16'h0011] = 8'hE7;
    mem[16'h0012] = 8'h3D;
    wait_cycles(3);

    // Reset values
    check("rst_tx_dv", {31'd0, tx_dv}, 32'd0);
    check("rst_tx_byte", {24'd0, tx_byte}, 32'd0);
    check("rst_req", {31'd0, mem_req}, 32'd0);
    check("rst_we", {31'd0, mem_we}, 32'd0);
    check("rst_addr", {16'd0, mem_addr}, 32'd0);
    check("rst_wdata", {24'd0, mem_wdata}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_err", {31'd0, err}, 32'd0);
    check("rst_state", {28'd0, dbg_state}, {28'd0, ST_IDLE});
    rst_n = 1'b1;
    wait_cycles(3);

    // Write burst 01 12 34 AA BB
    exp_wr(16'h1234, 8'hAA);
    exp_wr(16'h1235, 8'hBB);
    cs_low();
    send_byte(8'h01, 10); send_byte(8'h12, 10); send_byte(8'h34, 10);
    send_byte(8'hAA, 10); send_byte(8'hBB, 10);
    cs_high();
    check("wr_err", {31'd0, err}, 32'd0);
    check("wr_state", {28'd0, dbg_state}, {28'd0, ST_IDLE});
    check("wr_busy", {31'd0, busy}, 32'd0);

    // Read burst 02 00 10 xx xx, prefetch of 0x0012 included
    exp_rd(16'h0010); exp_rd(16'h0011); exp_rd(16'h0012);
    exp_tx_q.push_back(8'h5C); exp_tx_q.push_back(8'hE7); exp_tx_q.push_back(8'h3D);
    cs_low();
    send_byte(8'h02, 10); send_byte(8'h00, 10); send_byte(8'h10, 10);
    send_byte(8'hFF, 10); send_byte(8'hFF, 10);
    cs_high();
    check("rd_state", {28'd0, dbg_state}, {28'd0, ST_IDLE});

    // Address wrap FFFF -> 0000
    exp_wr(16'hFFFF, 8'h11);
    exp_wr(16'h0000, 8'h22);
    cs_low();
    send_byte(8'h01, 10); send_byte(8'hFF, 10); send_byte(8'hFF, 10);
    send_byte(8'h11, 10); send_byte(8'h22, 10);
    cs_high();
    check("wrap_err", {31'd0, err}, 32'd0);

    // Illegal command; following byte ignored
    cs_low();
    send_byte(8'h7F, 10); send_byte(8'h01, 10);
    cs_high();
    check("ill_err", {31'd0, err}, 32'd1);
    check("ill_state", {28'd0, dbg_state}, {28'd0, ST_IDLE});

    // STATUS: A5, flags (illegal), then 00; flags cleared
    exp_tx_q.push_back(8'hA5); exp_tx_q.push_back(8'h01); exp_tx_q.push_back(8'h00);
    cs_low();
    send_byte(8'h03, 10); send_byte(8'h00, 10); send_byte(8'h00, 10);
    cs_high();
    check("stat_err_clr", {31'd0, err}, 32'd0);

    // Overrun: byte arrives while write waits on slow ack
    mem_lat = 20;
    exp_wr(16'h0040, 8'hC1);
    exp_wr(16'h0041, 8'hC3);
    cs_low();
    send_byte(8'h01, 10); send_byte(8'h00, 10); send_byte(8'h40, 10);
    send_byte(8'hC1, 8);
    send_byte(8'hC2, 20);
    send_byte(8'hC3, 30);
    cs_high();
    check("ovr_err", {31'd0, err}, 32'd1);
    mem_lat = 0;
    exp_tx_q.push_back(8'hA5); exp_tx_q.push_back(8'h02);
    cs_low();
    send_byte(8'h03, 10); send_byte(8'h00, 10);
    cs_high();
    check("ovr_err_clr", {31'd0, err}, 32'd0);

    // CS rises with a write outstanding: drain then idle
    mem_lat = 20;
    exp_wr(16'h0050, 8'hD1);
    cs_low();
    send_byte(8'h01, 10); send_byte(8'h00, 10); send_byte(8'h50, 10);
    send_byte(8'hD1, 2);
    @(negedge clk);
    cs_n = 1'b1;
    wait_cycles(4);
    check("drain_state", {28'd0, dbg_state}, {28'd0, ST_DRAIN});
    check("drain_req", {31'd0, mem_req}, 32'd1);
    cnt = 0;
    while (mem_req && cnt < 60) begin
      @(negedge clk);
      cnt++;
    end
    check("drain_req_done", {31'd0, mem_req}, 32'd0);
    @(negedge clk);
    check("drain_idle", {28'd0, dbg_state}, {28'd0, ST_IDLE});
    wait_cycles(10);
    check("drain_no_req", {31'd0, mem_req}, 32'd0);

    // Reset in the middle of a read fetch
    cs_low();
    send_byte(8'h02, 2); send_byte(8'h00, 2); send_byte(8'h60, 2);
    check("rfetch_state", {28'd0, dbg_state}, {28'd0, ST_RD_FETCH});
    check("rfetch_req", {31'd0, mem_req}, 32'd1);
    @(negedge clk);
    rst_n = 1'b0;
    cs_n  = 1'b1;
    #1;
    check("mrst_req", {31'd0, mem_req}, 32'd0);
    check("mrst_busy", {31'd0, busy}, 32'd0);
    check("mrst_addr", {16'd0, mem_addr}, 32'd0);
    check("mrst_tx_dv", {31'd0, tx_dv}, 32'd0);
    wait_cycles(3);
    rst_n   = 1'b1;
    mem_lat = 1;
    wait_cycles(3);
    check("mrst_no_req", {31'd0, mem_req}, 32'd0);

    // Next transaction decodes normally
    exp_rd(16'h0010); exp_rd(16'h0011);
    exp_tx_q.push_back(8'h5C); exp_tx_q.push_back(8'hE7);
    cs_low();
    send_byte(8'h02, 10); send_byte(8'h00, 10); send_byte(8'h10, 10);
    send_byte(8'hFF, 10);
    cs_high();
    check("post_rst_err", {31'd0, err}, 32'd0);

`ifdef SPI_CMD_CKSUM_EN
    // Checksum of bytes written since reset, cleared on readout
    mem_lat = 0;
    exp_wr(16'h0100, 8'h10); exp_wr(16'h0101, 8'h20); exp_wr(16'h0102, 8'h30);
    cs_low();
    send_byte(8'h01, 10); send_byte(8'h01, 10); send_byte(8'h00, 10);
    send_byte(8'h10, 10); send_byte(8'h20, 10); send_byte(8'h30, 10);
    cs_high();
    exp_tx_q.push_back(8'h60);
    cs_low(); send_byte(8'h04, 10); cs_high();
    exp_tx_q.push_back(8'h00);
    cs_low(); send_byte(8'h04, 10); cs_high();
    check("cksum_err", {31'd0, err}, 32'd0);
`else
    // Without the checksum feature 0x04 is illegal
    cs_low(); send_byte(8'h04, 10); cs_high();
    check("cmd04_illegal", {31'd0, err}, 32'd1);
    exp_tx_q.push_back(8'hA5); exp_tx_q.push_back(8'h01);
    cs_low();
    send_byte(8'h03, 10); send_byte(8'h00, 10);
    cs_high();
    check("cmd04_err_clr", {31'd0, err}, 32'd0);
`endif

    // All expected events must have been observed
    wait_cycles(10);
    check("req_q_empty", exp_req_q.size(), 32'd0);
    check("tx_q_empty", exp_tx_q.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/spi_cmd_ctrl.md
Name: spi_cmd_ctrl

Overview:
- Command sequencer on the FPGA-clock side of the SPI slave byte interface.
- Consumes received-byte pulses, decodes a 3-byte header (command, address hi, address lo) and runs byte-wide memory write or read bursts on a req/ack memory port.
- Loads reply bytes for MISO through the slave's TX load pulse.
- Lets the host load and verify emulated ROM/RAM contents.

Parameters:
- ADDR_W, 16, memory address width; header address truncated to ADDR_W LSBs.
- STATUS_ID, 8'hA5, constant returned as first reply byte of STATUS command.

Ports:
- i_Clk  in  1  FPGA clock
- i_Rst_L  in  1  reset, asynchronous, active-low
- i_RX_DV  in  1  one-cycle pulse: i_RX_Byte valid
- i_RX_Byte  in  8  byte received from host
- i_SPI_CS_n  in  1  raw chip select, asynchronous to i_Clk
- o_TX_DV  out  1  one-cycle pulse: load o_TX_Byte into slave
- o_TX_Byte  out  8  next reply byte
- o_Mem_Req  out  1  memory request, held until ack
- o_Mem_We  out  1  1 = write, 0 = read; valid with req
- o_Mem_Addr  out  ADDR_W  memory address
- o_Mem_Wdata  out  8  write data
- i_Mem_Ack  in  1  one-cycle completion; i_Mem_Rdata valid same cycle
- i_Mem_Rdata  in  8  read data
- o_Busy  out  1  state != IDLE
- o_Err  out  1  sticky error flag

Behaviour:
- Reset: state IDLE; all outputs 0; address 0; error flags 0.
- Reset mid-burst aborts immediately; no further req.
- CS sync:
  - i_SPI_CS_n passes through a 2-flop synchronizer.
  - A synchronized rising edge (end of transaction) forces state IDLE within 3 cycles.
  - If o_Mem_Req is high at that point, the block goes to DRAIN, holds req until ack, then goes IDLE.
- Commands (first byte after CS falls):
  - 0x01 WRITE
  - 0x02 READ
  - 0x03 STATUS
  - anything else: set illegal-command flag, enter ERR; ERR ignores bytes until CS rises.
- States and transitions:
  - IDLE -> CMD on synchronized CS falling edge.
  - CMD: on RX_DV, decode the command.
    - STATUS: TX_DV next cycle with STATUS_ID, then HOLD.
    - WRITE/READ: go to ADDR_HI.
  - ADDR_HI -> ADDR_LO on RX_DV.
  - ADDR_LO on RX_DV:
    - WRITE: go to WR_DATA.
    - READ: go to RD_FETCH.
  - WR_DATA: on RX_DV, req=1, we=1, addr, wdata=byte; go to WR_WAIT.
  - WR_WAIT: on ack, req=0, addr+1; go to WR_DATA.
  - RD_FETCH: req=1, we=0; on ack, TX_DV the following cycle with o_TX_Byte=rdata, addr+1; go to RD_DATA.
  - RD_DATA: on RX_DV (host's dummy byte), go to RD_FETCH.
  - HOLD (STATUS): 2nd byte time TX={6'b0, overrun, illegal}; flags clear on that load; later bytes reply 0x00.
- Read latency: first data byte is returned during the 4th SPI byte. Host must leave an inter-byte gap of at least (memory latency + 4) i_Clk cycles.
- Address wraps 2^ADDR_W-1 -> 0 silently.
- Overrun: RX_DV while in WR_WAIT or DRAIN sets the sticky overrun flag; that byte is dropped and the burst continues.
- Simultaneous RX_DV and CS rise: CS wins; byte is discarded.
- o_Err = overrun | illegal. Cleared only by reset or a STATUS read.

Optional Feature:
- Macro SPI_CMD_CKSUM_EN.
- Defined:
  - 8-bit wrapping sum of every byte written to memory since reset or the last readout.
  - Command 0x04 returns the sum as the first reply byte and clears it on that TX_DV.
- Undefined: 0x04 is an illegal command; no sum register exists.

Decomposition:
- Package spi_cmd_pkg holds:
  - command codes (CMD_WRITE, CMD_READ, CMD_STATUS, CMD_CKSUM)
  - state enum
  - STATUS flag bit positions
- Sub-module cdc_sync2: generic 2-flop synchronizer, reset to 1 so CS reads as idle.

Test Plan:
- Write burst: CS low, bytes 01 12 34 AA BB, CS high -> mem writes 0x1234=AA, 0x1235=BB; o_Err=0; IDLE.
- Read burst: memory 0x0010=5C, 0x0011=E7; bytes 02 00 10 xx xx -> TX_DV carries 5C then E7; reads at 0x0010, 0x0011, 0x0012 (prefetch).
- Wrap and illegal command: WRITE at FFFF with 2 data bytes -> addresses FFFF then 0000. Command 7F -> o_Err=1. STATUS 03 xx -> replies A5, 01; o_Err then 0.
- Stalls: ack delayed 20 cycles with RX_DV inside WR_WAIT -> overrun set, byte dropped. CS raised with req pending -> req held until ack, then IDLE, no new req.
- Reset mid-read (i_Rst_L low during RD_FETCH) -> all outputs 0 immediately; next transaction decodes normally.
- SPI_CMD_CKSUM_EN: write 10 20 30 then command 04 -> reply 0x60; repeat 04 -> 0x00. Without the macro, 04 sets illegal.
